// File: rtl/sm_addsub_if.sv
// Handshake bus for the sign-magnitude add/sub pipeline: input operation channel,
// output result channel and the accumulator readout.
interface sm_addsub_if #(
  parameter int unsigned W = 24
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x_sm;
  logic [W-1:0] y_sm;
  logic [1:0]   op;
  logic         clr;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sr_sm;
  logic         sat;
  logic [W-1:0] acc_sm;

  modport master (
    output in_valid, x_sm, y_sm, op, clr, out_ready,
    input  in_ready, out_valid, sr_sm, sat, acc_sm
  );

  modport slave (
    input  in_valid, x_sm, y_sm, op, clr, out_ready,
    output in_ready, out_valid, sr_sm, sat, acc_sm
  );
endinterface

// File: rtl/sm_addsub_pipe.sv
// Two-stage saturating sign-magnitude adder/subtractor with accumulator mode.
// Stage A converts operands to two's complement; stage B adds, clips and converts back.
module sm_addsub_pipe #(
  parameter int unsigned W = 24
) (
  input logic        clk,
  input logic        rst,
  sm_addsub_if.slave bus
);

  // Sign-magnitude to (W+1)-bit two's complement; negative zero maps to +0.
  function automatic logic signed [W:0] to_tc(input logic [W-1:0] v);
    logic signed [W:0] m;
    m = $signed({2'b00, v[W-2:0]});
    return v[W-1] ? -m : m;
  endfunction

  logic                a_valid_q;
  logic [1:0]          a_op_q;
  logic                a_clr_q;
  logic signed [W:0]   a_x_q;
  logic signed [W:0]   a_y_q;

  logic                out_valid_q;
  logic [W-1:0]        sr_q;
  logic                sat_q;
  logic [W-1:0]        acc_q;

  logic                b_en;
  logic                a_en;
  logic signed [W:0]   base;
  logic signed [W:0]   res;
  logic [W:0]          mag_full;
  logic                sat_d;
  logic [W-1:0]        sr_d;

  assign b_en = !out_valid_q || bus.out_ready;
  assign a_en = !a_valid_q || b_en;

  always_comb begin
    base     = a_clr_q ? '0 : to_tc(acc_q);
    res      = '0;
    unique case (a_op_q)
      2'b00: res = a_x_q + a_y_q;
      2'b01: res = a_x_q - a_y_q;
      2'b10: res = base + a_x_q;
      2'b11: res = base - a_x_q;
      default: res = '0;
    endcase
    // |res| < 2^W always, so any set bit above W-2 means it exceeds full scale.
    mag_full = res[W] ? $unsigned(-res) : $unsigned(res);
    sat_d    = |mag_full[W:W-1];
    sr_d     = {res[W], sat_d ? {(W-1){1'b1}} : mag_full[W-2:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_valid_q <= 1'b0;
      a_op_q    <= 2'b00;
      a_clr_q   <= 1'b0;
      a_x_q     <= '0;
      a_y_q     <= '0;
    end else if (a_en) begin
      a_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        a_op_q  <= bus.op;
        a_clr_q <= bus.clr;
        a_x_q   <= to_tc(bus.x_sm);
        a_y_q   <= to_tc(bus.y_sm);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sr_q        <= '0;
      sat_q       <= 1'b0;
      acc_q       <= '0;
    end else if (b_en) begin
      out_valid_q <= a_valid_q;
      if (a_valid_q) begin
        sr_q  <= sr_d;
        sat_q <= sat_d;
        if (a_op_q[1]) begin
          acc_q <= sr_d;
        end else if (a_clr_q) begin
          acc_q <= '0;
        end
      end
    end
  end

  assign bus.in_ready  = a_en;
  assign bus.out_valid = out_valid_q;
  assign bus.sr_sm     = sr_q;
  assign bus.sat       = sat_q;
  assign bus.acc_sm    = acc_q;

endmodule

// File: tb/tb_sm_addsub_pipe.sv
// Randomised and directed bench for sm_addsub_pipe against an integer reference model
// of the saturating add/sub and accumulator, tracked through an expected-result queue.
module tb_sm_addsub_pipe;
  localparam int W = 24;

  typedef struct packed {
    logic [W-1:0] sr;
    logic         sat;
    logic [W-1:0] acc;
  } exp_t;

  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  sm_addsub_if #(.W(W)) bus ();

  sm_addsub_pipe #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int           n_checks;
  int           n_errors;
  exp_t         exp_q[$];
  logic [W-1:0] got_q[$];
  logic         gsat_q[$];
  int           dcyc_q[$];
  int           acc_m;
  int           stepn;
  int           acc_step;
  int           n_acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int sm2i(input logic [W-1:0] v);
    int m;
    m = int'(v[W-2:0]);
    return v[W-1] ? -m : m;
  endfunction

  function automatic logic [W-1:0] i2sm(input int r);
    int a;
    a = (r < 0) ? -r : r;
    return {r < 0, (W-1)'(a)};
  endfunction

  task automatic model_push(input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic [1:0] o, input logic c);
    int xv, yv, base, r, lim;
    logic s;
    xv   = sm2i(x);
    yv   = sm2i(y);
    base = c ? 0 : acc_m;
    lim  = (1 << (W - 1)) - 1;
    case (o)
      2'd0:    r = xv + yv;
      2'd1:    r = xv - yv;
      2'd2:    r = base + xv;
      default: r = base - xv;
    endcase
    s = 1'b0;
    if (r > lim) begin
      r = lim;
      s = 1'b1;
    end else if (r < -lim) begin
      r = -lim;
      s = 1'b1;
    end
    if (o[1]) acc_m = r;
    else if (c) acc_m = 0;
    exp_q.push_back('{sr: i2sm(r), sat: s, acc: i2sm(acc_m)});
  endtask

  // One clock cycle: drive at the falling edge, observe 1ns later, transfer at the rising edge.
  task automatic step(input logic vld, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic [1:0] o, input logic c, input logic ordy, output logic ok);
    exp_t e;
    @(negedge clk);
    bus.in_valid  = vld;
    bus.x_sm      = x;
    bus.y_sm      = y;
    bus.op        = o;
    bus.clr       = c;
    bus.out_ready = ordy;
    #1;
    ok = vld && bus.in_ready;
    if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        check("stale_out", 32'(bus.out_valid), 32'd0);
      end else begin
        e = exp_q[0];
        check("sr_sm", 32'(bus.sr_sm), 32'(e.sr));
        check("sat", 32'(bus.sat), 32'(e.sat));
        check("acc_sm", 32'(bus.acc_sm), 32'(e.acc));
        if (ordy) begin
          void'(exp_q.pop_front());
          got_q.push_back(bus.sr_sm);
          gsat_q.push_back(bus.sat);
          dcyc_q.push_back(stepn);
        end
      end
    end
    if (ok) begin
      model_push(x, y, o, c);
      acc_step = stepn;
      n_acc++;
    end
    stepn++;
  endtask

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic [1:0] o,
                      input logic c);
    logic ok;
    int   n;
    n = 0;
    do begin
      step(1'b1, x, y, o, c, 1'b1, ok);
      n++;
    end while (!ok && n < 200);
    if (!ok) check("send_timeout", 32'(ok), 32'd1);
  endtask

  task automatic drain();
    logic ok;
    int   n;
    n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 50) begin
      step(1'b0, '0, '0, 2'b00, 1'b0, 1'b1, ok);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic clear_log();
    got_q.delete();
    gsat_q.delete();
    dcyc_q.delete();
    n_acc = 0;
  endtask

  task automatic single(input logic [W-1:0] x, input logic [W-1:0] y, input logic [1:0] o,
                        input logic [W-1:0] exp_sr, input logic exp_sat);
    clear_log();
    send(x, y, o, 1'b0);
    drain();
    check("single_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() == 1) begin
      check("single_sr", 32'(got_q[0]), 32'(exp_sr));
      check("single_sat", 32'(gsat_q[0]), 32'(exp_sat));
      check("single_latency", 32'(dcyc_q[0] - acc_step), 32'd2);
    end
  endtask

  function automatic logic [W-1:0] rnd_sm();
    case ($urandom_range(0, 3))
      0:       return {1'($urandom_range(0, 1)), {(W-1){1'b1}}};
      1:       return {1'($urandom_range(0, 1)), (W-1)'($urandom_range(0, 15))};
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic ok;
    int   k;
    int   n;
    n_checks      = 0;
    n_errors      = 0;
    acc_m         = 0;
    stepn         = 0;
    acc_step      = 0;
    n_acc         = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.x_sm      = '0;
    bus.y_sm      = '0;
    bus.op        = 2'b00;
    bus.clr       = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_sr_sm", 32'(bus.sr_sm), 32'd0);
    check("rst_sat", 32'(bus.sat), 32'd0);
    check("rst_acc_sm", 32'(bus.acc_sm), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    single(24'h000002, 24'h000003, 2'b00, 24'h000005, 1'b0);
    single(24'h000005, 24'h000007, 2'b01, 24'h800002, 1'b0);
    single(24'h7FFFFF, 24'h000001, 2'b00, 24'h7FFFFF, 1'b1);
    single(24'h800000, 24'h000000, 2'b01, 24'h000000, 1'b0);

    // Back-to-back accumulate chain
    clear_log();
    send(24'h000003, 24'h0, 2'b10, 1'b1);
    send(24'h000005, 24'h0, 2'b11, 1'b0);
    send(24'h000001, 24'h0, 2'b10, 1'b0);
    drain();
    check("chain_count", 32'(got_q.size()), 32'd3);
    if (got_q.size() == 3) begin
      check("chain_sr0", 32'(got_q[0]), 32'h000003);
      check("chain_sr1", 32'(got_q[1]), 32'h800002);
      check("chain_sr2", 32'(got_q[2]), 32'h800001);
      check("chain_gap01", 32'(dcyc_q[1] - dcyc_q[0]), 32'd1);
      check("chain_gap12", 32'(dcyc_q[2] - dcyc_q[1]), 32'd1);
    end
    check("chain_acc", 32'(bus.acc_sm), 32'h800001);

    clear_log();
    send(24'h7FFFFF, 24'h0, 2'b11, 1'b0);
    drain();
    check("accsat_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() == 1) begin
      check("accsat_sr", 32'(got_q[0]), 32'hFFFFFF);
      check("accsat_sat", 32'(gsat_q[0]), 32'd1);
    end
    check("accsat_acc", 32'(bus.acc_sm), 32'hFFFFFF);

    // Backpressure: capacity of two, then random release
    clear_log();
    k = 1;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, W'(k), '0, 2'b00, 1'b0, 1'b0, ok);
      if (ok) k++;
    end
    check("bp_accepted", 32'(n_acc), 32'd2);
    check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    n = 0;
    while (k <= 4 && n < 200) begin
      step(1'b1, W'(k), '0, 2'b00, 1'b0, 1'($urandom_range(0, 1)), ok);
      if (ok) k++;
      n++;
    end
    drain();
    check("bp_count", 32'(got_q.size()), 32'd4);
    if (got_q.size() == 4) begin
      for (int i = 0; i < 4; i++) check("bp_order", 32'(got_q[i]), 32'(i + 1));
    end

    // Reset with two transactions in flight
    step(1'b1, 24'h000007, '0, 2'b00, 1'b0, 1'b0, ok);
    step(1'b1, 24'h000009, '0, 2'b00, 1'b0, 1'b0, ok);
    @(negedge clk);
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    acc_m = 0;
    #1;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_acc_sm", 32'(bus.acc_sm), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    clear_log();
    repeat (5) step(1'b0, '0, '0, 2'b00, 1'b0, 1'b1, ok);
    check("mid_rst_no_stale", 32'(got_q.size()), 32'd0);

    // Random regression
    clear_log();
    for (int i = 0; i < 1000; i++) begin
      step($urandom_range(0, 3) != 0, rnd_sm(), rnd_sm(), 2'($urandom_range(0, 3)),
           $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, ok);
    end
    drain();
    check("rand_count", 32'(got_q.size()), 32'(n_acc));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
